ball_renderer: RTL and testbench
================================

# ball_renderer

Downstream consumer of the line drawer's pixel-coordinate stream. Whenever the ball position (`in_x`, `in_y`) changes, it erases the square ball at the previously drawn position (black) and then draws it at the new position (white). It issues one pixel write per accepted cycle to the framebuffer write port of the 640x480 VGA display.

## Interface
- `BALL_SIZE`, default 4: ball square edge in pixels, range 1..16; the square's top-left corner is at the ball coordinate.
- `X_MAX`, default 639: last visible column; pixels with x > X_MAX or x < 0 are clipped.
- `Y_MAX`, default 479: last visible row; pixels with y > Y_MAX or y < 0 are clipped.
- `clk`, input, 1: 50 MHz system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_x`, input, 11 signed: current ball x from the line drawer.
- `in_y`, input, 11 signed: current ball y from the line drawer.
- `in_done`, input, 1: line drawer done flag; informational only, used in busy reporting.
- `px_ready`, input, 1: framebuffer accepts the pixel presented this cycle.
- `px_we`, output, 1: pixel write request.
- `px_x`, output, 10 unsigned: pixel column.
- `px_y`, output, 9 unsigned: pixel row.
- `px_color`, output, 1: 1 = white (draw), 0 = black (erase).
- `busy`, output, 1: high outside IDLE.
- `frame_done`, output, 1: one-cycle pulse when the last pixel of a draw pass is accepted.

## Operation
- Registers:
  - `prev_x`/`prev_y`: last drawn origin.
  - `has_prev`: a ball is on screen.
  - `cur_x`/`cur_y`: origin being processed.
  - `row`/`col` offset counters: 0..BALL_SIZE-1.
- States:
  - IDLE:
    - If `has_prev`=0, or (`in_x`,`in_y`) differs from (`prev_x`,`prev_y`), latch `in_x`/`in_y` into `cur_x`/`cur_y` and clear `row`/`col`.
    - Then go to ERASE if `has_prev`=1, otherwise to DRAW.
  - ERASE:
    - Scans `prev` origin plus (`col`,`row`) with `px_color`=0.
    - After the last offset is retired, clear the counters and go to DRAW.
  - DRAW:
    - Scans `cur` origin plus offset with `px_color`=1.
    - After the last offset is retired: `prev` <= `cur`, `has_prev` <= 1, pulse `frame_done`, go to IDLE.
- Scan order: `col` is the inner loop and `row` the outer loop, raster order from (0,0) to (BALL_SIZE-1, BALL_SIZE-1).
- Coordinate arithmetic uses 12-bit signed sums. In-range results are truncated to `px_x`[9:0] and `px_y`[8:0].
- Clipping: an out-of-range offset is retired in one cycle with `px_we`=0 and no handshake.
- Handshake:
  - An in-range pixel holds `px_we`=1 with `px_x`, `px_y` and `px_color` stable until the cycle in which `px_ready`=1.
  - The offset advances on that edge.
- Input changes during ERASE or DRAW are ignored. IDLE resamples the inputs, so intermediate positions are coalesced.
- `busy` = (state != IDLE). `in_done` does not affect the FSM.

## Timing
- Reset values:
  - `px_we`=0, `px_x`=0, `px_y`=0, `px_color`=0.
  - `busy`=0, `frame_done`=0.
  - `has_prev`=0, state IDLE, `prev`/`cur`/counters = 0.
- Latency: a position change visible in IDLE at edge n gives `px_we`=1 in cycle n+1, presenting the first erase pixel.
- With `px_ready` held at 1 and no clipping, each pass takes BALL_SIZE² cycles. A full update takes 1 + 2·BALL_SIZE² cycles, IDLE to IDLE (33 for the default size).
- `frame_done` is high in the cycle after the final DRAW acceptance, coincident with `busy`=0.
- Outputs are registered, with no combinational path from inputs to outputs. `px_ready` only gates advancement at the edge.
- Reset mid-pass, synchronous: on the reset edge all registers take their reset values and `px_we` drops in the following cycle. The erased or partial ball stays on screen. The next pass is a DRAW-only pass.
- If `px_ready`=1 while `px_we`=0, it is ignored.

## Configuration
- `BALL_RENDERER_TRAIL_EN` defined:
  - The ERASE state is compiled out and IDLE always goes to DRAW.
  - The old ball remains on screen, leaving a trail (debug/demo mode).
  - A full update takes 1 + BALL_SIZE² cycles.
- Undefined: erase-then-draw exactly as specified above.

## Structure
- Shared package `ball_pkg`:
  - `coord_t` (logic signed [10:0]).
  - `SCREEN_W`=640, `SCREEN_H`=480.
  - Enum `render_state_t` {IDLE, ERASE, DRAW}.
- Sub-module `square_scanner`:
  - Inputs: `clk`, `reset`, `clear`, `advance`.
  - Outputs: `col`, `row`, `last`.
  - Parameterised by BALL_SIZE; instantiated once and reused by both passes.

## Test plan
- Reset then `in_x`=20, `in_y`=20, `px_ready`=1 -> 16 white writes covering (20..23, 20..23) in raster order, `frame_done` pulse at cycle 17, no erase writes.
- Move to (21,22) -> 16 black writes at (20..23, 20..23), then 16 white writes at (21..24, 22..25); `busy` is high for 32 cycles.
- `px_ready` toggled 1,0,0,1,... -> each pixel is held stable while `px_ready`=0, with no lost or duplicated pixels (32 acceptances total).
- Position (637,478) -> only pixels with x in 637..639 and y in 478..479 are written (6 writes); clipped offsets spend one cycle each with `px_we`=0.
- Input changes to (30,30) and then (31,30) during DRAW -> only (31,30) is rendered after IDLE; (30,30) never appears.
- `reset` asserted on the 5th erase cycle -> `px_we`=0 the next cycle and `busy`=0. The next update emits 16 white writes only. With `BALL_RENDERER_TRAIL_EN` defined, the move in the second scenario produces only 16 white writes.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball renderer and its offset scanner.
// Build option: BALL_RENDERER_TRAIL_EN (see ball_renderer.sv).
package ball_pkg;

    typedef logic signed [10:0] coord_t;
    typedef logic [3:0]         offset_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW
    } render_state_t;

    // Origin plus offset as a 12-bit signed sum so negative and off-screen results stay visible to clipping.
    function automatic logic signed [11:0] offset_coord(input coord_t base, input offset_t off);
        return $signed({base[10], base}) + $signed({8'd0, off});
    endfunction

endpackage

// File: rtl/square_scanner.sv
// Raster-order (col inner, row outer) offset counter for a BALL_SIZE x BALL_SIZE square.
// next_col/next_row expose the value the counters take at the coming edge.
module square_scanner
    import ball_pkg::*;
#(
    parameter int BALL_SIZE = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    advance,
    output offset_t col,
    output offset_t row,
    output offset_t next_col,
    output offset_t next_row,
    output logic    last
);

    localparam offset_t LAST_OFF = offset_t'(BALL_SIZE - 1);

    always_comb begin
        next_col = col;
        next_row = row;
        if (clear) begin
            next_col = '0;
            next_row = '0;
        end else if (advance) begin
            if (col == LAST_OFF) begin
                next_col = '0;
                next_row = (row == LAST_OFF) ? '0 : row + 1'b1;
            end else begin
                next_col = col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= next_col;
            row <= next_row;
        end
    end

    assign last = (col == LAST_OFF) && (row == LAST_OFF);

endmodule

// File: rtl/ball_renderer.sv
// Erases the ball at its previous origin and redraws it at the new one, one framebuffer write per accepted cycle.
// Build option: define BALL_RENDERER_TRAIL_EN to drop the erase pass and leave a trail.
module ball_renderer
    import ball_pkg::*;
#(
    parameter int BALL_SIZE = 4,
    parameter int X_MAX     = SCREEN_W - 1,
    parameter int Y_MAX     = SCREEN_H - 1
) (
    input  logic       clk,
    input  logic       reset,
    input  coord_t     in_x,
    input  coord_t     in_y,
    input  logic       in_done,
    input  logic       px_ready,
    output logic       px_we,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic       px_color,
    output logic       busy,
    output logic       frame_done
);

    render_state_t state;
    coord_t        prev_x, prev_y;
    coord_t        cur_x, cur_y;
    logic          has_prev;

    offset_t scan_col, scan_row, next_col, next_row;
    logic    scan_last, scan_clear, advance, start;

    logic                next_erase;
    coord_t              next_ox, next_oy;
    logic signed [11:0]  sum_x, sum_y;
    logic                next_visible;

    logic unused_bits;
    assign unused_bits = ^{in_done, scan_col, scan_row};

    square_scanner #(
        .BALL_SIZE(BALL_SIZE)
    ) scanner (
        .clk     (clk),
        .reset   (reset),
        .clear   (scan_clear),
        .advance (advance),
        .col     (scan_col),
        .row     (scan_row),
        .next_col(next_col),
        .next_row(next_row),
        .last    (scan_last)
    );

    // Work out which pixel the registered outputs will present after this edge.
    always_comb begin
        start      = (state == IDLE) && (!has_prev || (in_x != prev_x) || (in_y != prev_y));
        advance    = (state != IDLE) && (!px_we || px_ready);
        scan_clear = start;
        next_erase = 1'b0;
`ifdef BALL_RENDERER_TRAIL_EN
        next_erase = 1'b0;
`else
        if ((state == ERASE) && advance && scan_last) begin
            scan_clear = 1'b1;
        end
        if (start) begin
            next_erase = has_prev;
        end else if (state == ERASE) begin
            next_erase = !(advance && scan_last);
        end
`endif
        next_ox = next_erase ? prev_x : (start ? in_x : cur_x);
        next_oy = next_erase ? prev_y : (start ? in_y : cur_y);
        sum_x   = offset_coord(next_ox, next_col);
        sum_y   = offset_coord(next_oy, next_row);
        next_visible = !sum_x[11] && (sum_x <= 12'(X_MAX)) &&
                       !sum_y[11] && (sum_y <= 12'(Y_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_x     <= '0;
            prev_y     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            has_prev   <= 1'b0;
            px_we      <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_color   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_x    <= in_x;
                        cur_y    <= in_y;
                        busy     <= 1'b1;
`ifdef BALL_RENDERER_TRAIL_EN
                        state    <= DRAW;
`else
                        state    <= has_prev ? ERASE : DRAW;
`endif
                        px_we    <= next_visible;
                        px_x     <= sum_x[9:0];
                        px_y     <= sum_y[8:0];
                        px_color <= !next_erase;
                    end
                end
`ifdef BALL_RENDERER_TRAIL_EN
`else
                ERASE: begin
                    if (advance) begin
                        if (scan_last) begin
                            state <= DRAW;
                        end
                        px_we    <= next_visible;
                        px_x     <= sum_x[9:0];
                        px_y     <= sum_y[8:0];
                        px_color <= !next_erase;
                    end
                end
`endif
                DRAW: begin
                    if (advance) begin
                        if (scan_last) begin
                            prev_x     <= cur_x;
                            prev_y     <= cur_y;
                            has_prev   <= 1'b1;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            px_we      <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            px_we    <= next_visible;
                            px_x     <= sum_x[9:0];
                            px_y     <= sum_y[8:0];
                            px_color <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    px_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: table vectors, hand-written corner sequences and random moves
// compared against a pixel-list model. Honours BALL_RENDERER_TRAIL_EN when defined.
module tb_ball_renderer;

    localparam int BS    = 4;
    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
`ifdef BALL_RENDERER_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic signed [10:0] in_x, in_y;
    logic               in_done;
    logic               px_ready;
    logic               px_we;
    logic [9:0]         px_x;
    logic [8:0]         px_y;
    logic               px_color;
    logic               busy;
    logic               frame_done;

    ball_renderer #(.BALL_SIZE(BS), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_done   (in_done),
        .px_ready  (px_ready),
        .px_we     (px_we),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int color;
    } pix_t;

    typedef struct {
        int x;
        int y;
        int mode;
        int erase_n;
        int draw_n;
    } vec_t;

    pix_t got[$];
    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_has_prev = 0;
    int   m_px = 0, m_py = 0;
    int   pend_x = 0, pend_y = 0;
    int   cur_mode = 0;
    int   cyc_idx = 0;
    int   busy_cnt = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit visible(input int x, input int y);
        return (x >= 0) && (x <= X_MAX) && (y >= 0) && (y <= Y_MAX);
    endfunction

    function automatic void addSquare(input int ox, input int oy, input int color);
        pix_t p;
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                if (visible(ox + c, oy + r)) begin
                    p.x = ox + c;
                    p.y = oy + r;
                    p.color = color;
                    exp_q.push_back(p);
                end
            end
        end
    endfunction

    function automatic int readyFor(input int mode, input int cyc);
        if (mode == 1) return ((cyc % 4) == 0 || (cyc % 4) == 3) ? 1 : 0;
        if (mode == 2) return ($urandom_range(0, 2) != 0) ? 1 : 0;
        return 1;
    endfunction

    function automatic int packPix(input pix_t p);
        return p.x * 2048 + p.y * 2 + p.color;
    endfunction

    // Any stalled pixel must still be presented unchanged on the next cycle; accepted pixels are logged.
    bit         stall_prev = 1'b0;
    logic [9:0] hold_x;
    logic [8:0] hold_y;
    logic       hold_c;
    always @(negedge clk) begin
        pix_t p;
        if (stall_prev) begin
            checkOutput("hold_we", int'(px_we), 1);
            checkOutput("hold_pixel", int'({px_x, px_y, px_color}), int'({hold_x, hold_y, hold_c}));
        end
        if (!reset && px_we && px_ready) begin
            p.x = int'(px_x);
            p.y = int'(px_y);
            p.color = int'(px_color);
            got.push_back(p);
        end
        stall_prev = !reset && px_we && !px_ready;
        hold_x = px_x;
        hold_y = px_y;
        hold_c = px_color;
    end

    task automatic applyStimulus(input int nx, input int ny, input int mode);
        int fx, fy;
        exp_q.delete();
        if (m_has_prev != 0 && !TRAIL) addSquare(m_px, m_py, 0);
        addSquare(nx, ny, 1);
        fx = (m_has_prev != 0 && !TRAIL) ? m_px : nx;
        fy = (m_has_prev != 0 && !TRAIL) ? m_py : ny;
        got.delete();
        pend_x = nx;
        pend_y = ny;
        in_x = 11'(nx);
        in_y = 11'(ny);
        in_done = ~in_done;
        cur_mode = mode;
        cyc_idx = 0;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        px_ready = 1'(readyFor(mode, cyc_idx));
        cyc_idx++;
        @(negedge clk);
        checkOutput("start_busy", int'(busy), 1);
        checkOutput("start_we", int'(px_we), int'(visible(fx, fy)));
        if (busy) busy_cnt++;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        px_ready = 1'(readyFor(cur_mode, cyc_idx));
        cyc_idx++;
        @(negedge clk);
        if (busy) busy_cnt++;
    endtask

    task automatic finishUpdate(input string name, input int exp_busy, input int exp_writes);
        int guard = 0;
        int n;
        while (!frame_done && guard < 3000) begin
            stepCycle();
            guard++;
        end
        checkOutput({name, "_frame_done"}, int'(frame_done), 1);
        checkOutput({name, "_idle_at_done"}, int'(busy), 0);
        if (exp_busy >= 0) checkOutput({name, "_busy_cycles"}, busy_cnt, exp_busy);
        if (exp_writes >= 0) checkOutput({name, "_write_count"}, got.size(), exp_writes);
        checkOutput({name, "_model_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_pix%0d", name, i), packPix(got[i]), packPix(exp_q[i]));
        end
        m_has_prev = 1;
        m_px = pend_x;
        m_py = pend_y;
    endtask

    task automatic runUpdate(input string name, input vec_t v);
        int exp_busy, exp_writes;
        bit two_pass;
        two_pass = (m_has_prev != 0) && !TRAIL;
        exp_writes = v.draw_n + (two_pass ? v.erase_n : 0);
        exp_busy = (v.mode == 0) ? BS * BS * (two_pass ? 2 : 1) : -1;
        applyStimulus(v.x, v.y, v.mode);
        finishUpdate(name, exp_busy, exp_writes);
        stepCycle();
        checkOutput({name, "_pulse_width"}, int'(frame_done), 0);
    endtask

    initial begin
        #4000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vec_t vecs[6];
        int   n30, nx, ny;

        vecs[0] = '{x: 20,  y: 20,  mode: 0, erase_n: 0,  draw_n: 16};
        vecs[1] = '{x: 21,  y: 22,  mode: 0, erase_n: 16, draw_n: 16};
        vecs[2] = '{x: 100, y: 50,  mode: 1, erase_n: 16, draw_n: 16};
        vecs[3] = '{x: 637, y: 478, mode: 0, erase_n: 16, draw_n: 6};
        vecs[4] = '{x: -2,  y: -3,  mode: 0, erase_n: 6,  draw_n: 2};
        vecs[5] = '{x: 5,   y: 5,   mode: 2, erase_n: 2,  draw_n: 16};

        reset = 1'b1;
        in_x = 11'sd20;
        in_y = 11'sd20;
        in_done = 1'b0;
        px_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_px_we", int'(px_we), 0);
        checkOutput("reset_px_x", int'(px_x), 0);
        checkOutput("reset_px_y", int'(px_y), 0);
        checkOutput("reset_px_color", int'(px_color), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runUpdate($sformatf("vec%0d", i), vecs[i]);
        end

        // Two moves while the pass is drawing must collapse into the latest one.
        applyStimulus(50, 60, 0);
        for (int g = 0; g < 100 && !(busy && px_color); g++) stepCycle();
        checkOutput("coalesce_reach_draw", int'(px_color), 1);
        in_x = 11'sd30;
        in_y = 11'sd30;
        stepCycle();
        stepCycle();
        in_x = 11'sd31;
        finishUpdate("coalesce_first", -1, -1);
        applyStimulus(31, 30, 0);
        finishUpdate("coalesce_second", BS * BS * (TRAIL ? 1 : 2), TRAIL ? 16 : 32);
        n30 = 0;
        foreach (got[i]) if (got[i].x == 30 && got[i].color == 1) n30++;
        checkOutput("coalesce_no_30", n30, 0);

        // Reset lands on the fifth cycle of the pass: four pixels accepted, then a draw-only update.
        applyStimulus(70, 70, 0);
        repeat (3) stepCycle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midreset_we", int'(px_we), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        reset = 1'b0;
        checkOutput("midreset_accepts", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checkOutput($sformatf("midreset_pix%0d", i), packPix(got[i]), packPix(exp_q[i]));
        end
        m_has_prev = 0;
        applyStimulus(70, 70, 0);
        finishUpdate("after_reset", 16, 16);

        for (int i = 0; i < 8; i++) begin
            do begin
                nx = int'($urandom_range(0, 680)) - 20;
                ny = int'($urandom_range(0, 520)) - 20;
            end while (nx == m_px && ny == m_py);
            applyStimulus(nx, ny, 2);
            finishUpdate($sformatf("rand%0d", i), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
